// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int unsigned N_BITS    = 32;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned LAST_ITER = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla.sv
// 32-bit adder built from eight 4-bit carry-lookahead blocks whose carries ripple block to block.
module cla
  import mult_pkg::*;
(
  input  logic [N_BITS-1:0] i_a,
  input  logic [N_BITS-1:0] i_b,
  input  logic              i_cin,
  output logic [N_BITS-1:0] o_sum,
  output logic              o_cout
);

  localparam int unsigned BLK_W = 4;
  localparam int unsigned N_BLK = N_BITS / BLK_W;

  logic [N_BLK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < int'(N_BLK); gi++) begin : g_blk
    logic [BLK_W-1:0] w_g;
    logic [BLK_W-1:0] w_p;
    logic [BLK_W:0]   w_cc;

    assign w_g = i_a[gi*BLK_W +: BLK_W] & i_b[gi*BLK_W +: BLK_W];
    assign w_p = i_a[gi*BLK_W +: BLK_W] ^ i_b[gi*BLK_W +: BLK_W];

    // Carries inside the block are computed in parallel from the block carry-in.
    assign w_cc[0] = w_c[gi];
    assign w_cc[1] = w_g[0] | (w_p[0] & w_cc[0]);
    assign w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cc[0]);

    assign o_sum[gi*BLK_W +: BLK_W] = w_p ^ w_cc[BLK_W-1:0];
    assign w_c[gi+1]                = w_cc[BLK_W];
  end

  assign o_cout = w_c[N_BLK];

endmodule

// File: rtl/mult_seq.sv
// Sequential 32x32 unsigned multiplier: one cla adder iterated 32 times, start/done handshake.
module mult_seq
  import mult_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*N_BITS-1:0]   product
);

  state_t            r_state;
  logic [N_BITS-1:0] r_mcand;
  logic [N_BITS-1:0] r_hi;
  logic [N_BITS-1:0] r_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;

  logic [N_BITS-1:0] w_addend;
  logic [N_BITS-1:0] w_sum;
  logic              w_cout;

  assign w_addend = r_lo[0] ? r_mcand : '0;

  cla u_add (
    .i_a    (r_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // FSM, counter and shift registers; the adder carry-out becomes the new top bit of hi.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= a;
            r_lo    <= b;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_hi  <= {w_cout, w_sum[N_BITS-1:1]};
          r_lo  <= {w_sum[0], r_lo[N_BITS-1:1]};
          r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
          if (r_cnt == CNT_W'(LAST_ITER)) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = {r_hi, r_lo};

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq: cycle-exact handshake timing and hand-computed products.
module tb_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;

  mult_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge (cycle T). Start is sampled at edge T; cycle T+k ends at edge T+k.
  // In cycles listed in p1/p2 a stray start (a=2,b=2) is driven, which must be ignored.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [63:0] exp,
                        input string tag, input int p1, input int p2);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 32'hDEADBEEF;
    b = 32'hCAFEF00D;
    for (int k = 1; k <= 33; k++) begin
      if (k == p1 || k == p2) begin
        start = 1'b1;
        a = 32'd2;
        b = 32'd2;
      end else begin
        start = 1'b0;
      end
      chk1($sformatf("%s_busy_c%0d", tag, k), busy, 1'b1);
      chk1($sformatf("%s_done_c%0d", tag, k), done, (k == 33));
      if (k == 33) chk64($sformatf("%s_product", tag), product, exp);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk1($sformatf("%s_busy_after", tag), busy, 1'b0);
    chk1($sformatf("%s_done_after", tag), done, 1'b0);
    chk64($sformatf("%s_product_held", tag), product, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk64("rst_product", product, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("idle_busy_%0d", i), busy, 1'b0);
      chk1($sformatf("idle_done_%0d", i), done, 1'b0);
      chk64($sformatf("idle_product_%0d", i), product, 64'd0);
    end

    run_op(32'd3, 32'd5, 64'd15, "m3x5", 0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "mmax", 0, 0);
    run_op(32'd0, 32'h12345678, 64'd0, "m0xb", 0, 0);
    run_op(32'h12345678, 32'd0, 64'd0, "max0", 0, 0);

    // Stray starts at edge T+10 and during DONE; the back-to-back start at T+34 must be taken.
    run_op(32'd7, 32'd9, 64'd63, "m7x9", 10, 33);
    run_op(32'd2, 32'd2, 64'd4, "m2x2_b2b", 0, 0);

    // Reset asserted for the single edge T+15 of a 100x200 run.
    a = 32'd100;
    b = 32'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k < 15; k++) begin
      chk1($sformatf("rstrun_done_c%0d", k), done, 1'b0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk64("midrst_product", product, 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("postrst_done_%0d", i), done, 1'b0);
      chk1($sformatf("postrst_busy_%0d", i), busy, 1'b0);
    end

    run_op(32'd100, 32'd200, 64'd20000, "m100x200", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
